// File: rtl/pb_conditioner_pkg.sv
// rtl/pb_conditioner_pkg.sv - shared game package: debounce FSM encoding and defaults
//
// Purpose : types and constants shared by the pushbutton conditioner and its
//           per-channel debounce sub-module.
// Contents: pb_state_e     - 2-bit debounce FSM state encoding
//           PB_DEBOUNCE_DEFAULT / PB_CNT_W_DEFAULT - default parameter values
//           pb_is_level()  - states in which the debounced level reads 1
package pb_conditioner_pkg;

  localparam int PB_DEBOUNCE_DEFAULT = 50000;
  localparam int PB_CNT_W_DEFAULT    = 20;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } pb_state_e;

  // The level stays high while a release is still being qualified, so a
  // short bounce on release never drops the output.
  function automatic logic pb_is_level(input pb_state_e s);
    return (s == ST_PRESSED) || (s == ST_RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/pb_debounce_chan.sv
// rtl/pb_debounce_chan.sv - one pushbutton channel: synchronizer, debounce FSM, press pulse
//
// Purpose : qualifies one raw, bouncing, asynchronous button input.
// Ports   : clk      - system clock, rising edge
//           rst      - asynchronous active-low reset
//           i_raw    - raw button input (asynchronous to clk)
//           o_level  - registered debounced level
//           o_press  - registered one-cycle pulse on a qualified press
module pb_debounce_chan
  import pb_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = PB_DEBOUNCE_DEFAULT,
  parameter int CNT_W           = PB_CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  pb_state_e        r_state;
  pb_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_level;
  logic             r_press;
  logic             w_press_nxt;
  logic             w_cnt_done;

  // Two-flop synchronizer; only r_sync2 is allowed to reach the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_cnt_done = (r_cnt == CNT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_press_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_sync2) begin
          w_state_nxt = ST_PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!r_sync2) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_cnt_done) begin
          w_state_nxt = ST_PRESSED;
          w_cnt_nxt   = '0;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      ST_PRESSED: begin
        if (!r_sync2) begin
          w_state_nxt = ST_RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        // Returning to PRESSED here is a rejected release bounce, never a
        // new press, so no pulse is generated on this path.
        if (r_sync2) begin
          w_state_nxt = ST_PRESSED;
          w_cnt_nxt   = '0;
        end else if (w_cnt_done) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      // Level is registered from the next state so it changes on the same
      // edge as the state without any combinational path to the output.
      r_level <= pb_is_level(w_state_nxt);
      r_press <= w_press_nxt;
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/pb_conditioner.sv
// rtl/pb_conditioner.sv - left/right pushbutton conditioner top
//
// Purpose : debounces the two game pushbuttons and produces clean levels plus
//           one-cycle press pulses; the channels are fully independent.
// Ports   : clk        - system clock, rising edge
//           rst        - asynchronous active-low reset
//           pbl_raw    - raw left button
//           pbr_raw    - raw right button
//           pbl / pbr  - registered debounced levels
//           pbl_press / pbr_press - one-cycle pulses on qualified presses
// DEBOUNCE_CYCLES must lie in 2..2^20 and fit in CNT_W bits.
module pb_conditioner #(
  parameter int DEBOUNCE_CYCLES = pb_conditioner_pkg::PB_DEBOUNCE_DEFAULT,
  parameter int CNT_W           = pb_conditioner_pkg::PB_CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic pbl_raw,
  input  logic pbr_raw,
  output logic pbl,
  output logic pbr,
  output logic pbl_press,
  output logic pbr_press
);

  logic w_l_level;
  logic w_l_press;
  logic w_r_level;
  logic w_r_press;

  pb_debounce_chan #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_chan_l (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (pbl_raw),
    .o_level (w_l_level),
    .o_press (w_l_press)
  );

  pb_debounce_chan #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_chan_r (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (pbr_raw),
    .o_level (w_r_level),
    .o_press (w_r_press)
  );

  assign pbl       = w_l_level;
  assign pbl_press = w_l_press;
  assign pbr       = w_r_level;
  assign pbr_press = w_r_press;

endmodule
